// File: rtl/mbus_err_pkg.sv
// Shared types and default widths for the MBus error-injection scheduler.
package mbus_err_pkg;

    localparam int unsigned SKIP_W_DEF   = 8;
    localparam int unsigned INJ_W_DEF    = 8;
    localparam int unsigned IDLE_CYC_DEF = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_IDLE = 3'd1,
        SKIP      = 3'd2,
        ARM       = 3'd3,
        INJECT    = 3'd4,
        DONE_ST   = 3'd5
    } sched_state_e;

    // Bus events derived from the synchronized MBus lines
    typedef struct packed {
        logic bus_idle;
        logic txn_start;
        logic txn_end;
    } bus_evt_t;

endpackage

// File: rtl/mbus_bus_monitor.sv
// Synchronizes raw MBus CLK/DATA and derives idle, transaction-start and transaction-end events.
module mbus_bus_monitor
    import mbus_err_pkg::*;
#(
    parameter int unsigned IDLE_CYC = IDLE_CYC_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     cin,
    input  logic     din,
    output bus_evt_t evt_c
);

    localparam int unsigned      CTR_W    = $clog2(IDLE_CYC + 1);
    localparam logic [CTR_W-1:0] IDLE_MAX = CTR_W'(IDLE_CYC);

    logic             cin_s1_q, cin_s1_d;
    logic             cin_s2_q, cin_s2_d;
    logic             din_s1_q, din_s1_d;
    logic             din_s2_q, din_s2_d;
    logic             din_prev_q, din_prev_d;
    logic [CTR_W-1:0] idle_ctr_q, idle_ctr_d;
    logic             idle_prev_q, idle_prev_d;
    logic             bus_idle;

    // Next-state for synchronizers, idle run-length counter and edge history
    always_comb begin
        cin_s1_d    = cin;
        cin_s2_d    = cin_s1_q;
        din_s1_d    = din;
        din_s2_d    = din_s1_q;
        din_prev_d  = din_s2_q;
        bus_idle    = (idle_ctr_q == IDLE_MAX);
        idle_prev_d = bus_idle;
        idle_ctr_d  = '0;
        if (cin_s2_q && din_s2_q) begin
            idle_ctr_d = bus_idle ? idle_ctr_q : idle_ctr_q + CTR_W'(1);
        end
    end

    // Registers; synchronizers reset to the idle-high bus level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cin_s1_q    <= 1'b1;
            cin_s2_q    <= 1'b1;
            din_s1_q    <= 1'b1;
            din_s2_q    <= 1'b1;
            din_prev_q  <= 1'b1;
            idle_ctr_q  <= '0;
            idle_prev_q <= 1'b0;
        end else begin
            cin_s1_q    <= cin_s1_d;
            cin_s2_q    <= cin_s2_d;
            din_s1_q    <= din_s1_d;
            din_s2_q    <= din_s2_d;
            din_prev_q  <= din_prev_d;
            idle_ctr_q  <= idle_ctr_d;
            idle_prev_q <= idle_prev_d;
        end
    end

    // Event decode: start is DATA falling while CLK high, end is the rising edge of idle
    always_comb begin
        evt_c.bus_idle  = bus_idle;
        evt_c.txn_start = din_prev_q & ~din_s2_q & cin_s2_q;
        evt_c.txn_end   = bus_idle & ~idle_prev_q;
    end

endmodule

// File: rtl/mbus_err_scheduler.sv
// Sequences clean/injected MBus transactions, toggling ERR_EN only while the bus is idle.
module mbus_err_scheduler
    import mbus_err_pkg::*;
#(
    parameter int unsigned SKIP_W   = SKIP_W_DEF,
    parameter int unsigned INJ_W    = INJ_W_DEF,
    parameter int unsigned IDLE_CYC = IDLE_CYC_DEF
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              START,
    input  logic              ABORT,
    input  logic [SKIP_W-1:0] SKIP_CNT,
    input  logic [INJ_W-1:0]  INJ_CNT,
    input  logic              CIN,
    input  logic              DIN,
    output logic              ERR_EN,
    output logic              BUSY,
    output logic              DONE,
    output logic [INJ_W-1:0]  INJ_DONE
);

    bus_evt_t     evt_c;
    sched_state_e state_q, state_d;
    logic [SKIP_W-1:0] skip_left_q, skip_left_d;
    logic [SKIP_W-1:0] skip_rld_q, skip_rld_d;
    logic [INJ_W-1:0]  inj_left_q, inj_left_d;
    logic [INJ_W-1:0]  inj_done_q, inj_done_d;
    logic              abort_q, abort_d;
    logic              err_en_q, err_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              abort_pend;

    mbus_bus_monitor #(
        .IDLE_CYC (IDLE_CYC)
    ) u_mon (
        .clk   (CLK),
        .rst_n (RESETn),
        .cin   (CIN),
        .din   (DIN),
        .evt_c (evt_c)
    );

    // Next-state, counter updates and registered output decode
    always_comb begin
        state_d     = state_q;
        skip_left_d = skip_left_q;
        skip_rld_d  = skip_rld_q;
        inj_left_d  = inj_left_q;
        inj_done_d  = inj_done_q;
        abort_d     = abort_q;
        abort_pend  = abort_q | ABORT;

        unique case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (START && !ABORT) begin
                    skip_left_d = SKIP_CNT;
                    skip_rld_d  = SKIP_CNT;
                    inj_left_d  = INJ_CNT;
                    inj_done_d  = '0;
                    state_d     = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (ABORT) begin
                    state_d = DONE_ST;
                end else if (evt_c.bus_idle) begin
                    if (inj_left_q == '0) begin
                        state_d = DONE_ST;
                    end else if (skip_left_q == '0) begin
                        state_d = ARM;
                    end else begin
                        state_d = SKIP;
                    end
                end
            end
            SKIP: begin
                if (ABORT) begin
                    state_d = DONE_ST;
                end else if (evt_c.txn_end) begin
                    skip_left_d = skip_left_q - SKIP_W'(1);
                    if (skip_left_q == SKIP_W'(1)) begin
                        state_d = ARM;
                    end
                end
            end
            ARM: begin
                // A transaction already under way takes priority over a pending abort
                abort_d = abort_pend;
                if (evt_c.txn_start) begin
                    state_d = INJECT;
                end else if (abort_pend && evt_c.bus_idle) begin
                    state_d = DONE_ST;
                end
            end
            INJECT: begin
                abort_d = abort_pend;
                if (evt_c.txn_end) begin
                    inj_done_d = (inj_done_q == '1) ? inj_done_q : inj_done_q + INJ_W'(1);
                    inj_left_d = inj_left_q - INJ_W'(1);
                    if ((inj_left_q == INJ_W'(1)) || abort_pend) begin
                        state_d = DONE_ST;
                    end else begin
                        skip_left_d = skip_rld_q;
                        state_d     = (skip_rld_q == '0) ? ARM : SKIP;
                    end
                end
            end
            DONE_ST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        err_en_d = (state_d == ARM) || (state_d == INJECT);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE_ST);
    end

    // State, counters and outputs; reset clears ERR_EN asynchronously
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= IDLE;
            skip_left_q <= '0;
            skip_rld_q  <= '0;
            inj_left_q  <= '0;
            inj_done_q  <= '0;
            abort_q     <= 1'b0;
            err_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_left_q <= skip_left_d;
            skip_rld_q  <= skip_rld_d;
            inj_left_q  <= inj_left_d;
            inj_done_q  <= inj_done_d;
            abort_q     <= abort_d;
            err_en_q    <= err_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ERR_EN   = err_en_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign INJ_DONE = inj_done_q;

endmodule

// File: tb/tb_mbus_err_scheduler.sv
// Directed bench for mbus_err_scheduler with a rule-level reference model checked every cycle.
module tb_mbus_err_scheduler;

    localparam int IDLE_CYC = 16;

    logic       CLK = 1'b0;
    logic       RESETn = 1'b0;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic [7:0] SKIP_CNT = '0;
    logic [7:0] INJ_CNT = '0;
    logic       CIN = 1'b1;
    logic       DIN = 1'b1;
    logic       ERR_EN;
    logic       BUSY;
    logic       DONE;
    logic [7:0] INJ_DONE;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    bit en_q[$];

    mbus_err_scheduler dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .START    (START),
        .ABORT    (ABORT),
        .SKIP_CNT (SKIP_CNT),
        .INJ_CNT  (INJ_CNT),
        .CIN      (CIN),
        .DIN      (DIN),
        .ERR_EN   (ERR_EN),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .INJ_DONE (INJ_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Bus view: history of synchronized (CLK,DATA) pairs, two samples behind the raw lines
    bit m_syn_cin[$] = '{1'b1};
    bit m_syn_din[$] = '{1'b1};
    bit m_raw_cin_prev = 1'b1, m_raw_din_prev = 1'b1;
    bit m_idle = 1'b0, m_tstart = 1'b0, m_tend = 1'b0;
    // Run bookkeeping
    bit m_run = 0, m_need_idle = 0, m_armed = 0, m_injecting = 0, m_ending = 0, m_stop = 0;
    int m_skip_left = 0, m_inj_left = 0, m_skip_val = 0, m_inj_done = 0;

    function automatic bit hist_idle();
        int n = m_syn_cin.size();
        if (n < IDLE_CYC) return 1'b0;
        for (int i = n - IDLE_CYC; i < n; i++)
            if (!(m_syn_cin[i] && m_syn_din[i])) return 1'b0;
        return 1'b1;
    endfunction

    // Model advance once per clock, reset asynchronously with the DUT
    always @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            m_syn_cin = '{1'b1};
            m_syn_din = '{1'b1};
            m_raw_cin_prev = 1'b1; m_raw_din_prev = 1'b1;
            m_idle = 0; m_tstart = 0; m_tend = 0;
            m_run = 0; m_need_idle = 0; m_armed = 0; m_injecting = 0; m_ending = 0; m_stop = 0;
            m_skip_left = 0; m_inj_left = 0; m_skip_val = 0; m_inj_done = 0;
        end else begin
            bit nidle;
            int n;
            if (m_ending) begin
                m_ending = 0;
                m_run = 0;
            end else if (!m_run) begin
                if (START && !ABORT) begin
                    m_run = 1; m_need_idle = 1; m_stop = 0;
                    m_skip_left = int'(SKIP_CNT); m_skip_val = int'(SKIP_CNT);
                    m_inj_left = int'(INJ_CNT); m_inj_done = 0;
                end
            end else if (m_need_idle) begin
                if (ABORT) begin
                    m_need_idle = 0; m_ending = 1;
                end else if (m_idle) begin
                    m_need_idle = 0;
                    if (m_inj_left == 0) m_ending = 1;
                    else if (m_skip_left == 0) m_armed = 1;
                end
            end else if (m_injecting) begin
                if (ABORT) m_stop = 1;
                if (m_tend) begin
                    if (m_inj_done < 255) m_inj_done++;
                    m_inj_left--;
                    m_injecting = 0;
                    if (m_inj_left == 0 || m_stop) m_ending = 1;
                    else begin
                        m_skip_left = m_skip_val;
                        if (m_skip_val == 0) m_armed = 1;
                    end
                end
            end else if (m_armed) begin
                if (ABORT) m_stop = 1;
                if (m_tstart) begin
                    m_armed = 0; m_injecting = 1;
                end else if (m_stop && m_idle) begin
                    m_armed = 0; m_ending = 1;
                end
            end else begin
                if (ABORT) m_ending = 1;
                else if (m_tend) begin
                    m_skip_left--;
                    if (m_skip_left == 0) m_armed = 1;
                end
            end
            // bus view for the next cycle
            nidle = hist_idle();
            m_syn_cin.push_back(m_raw_cin_prev);
            m_syn_din.push_back(m_raw_din_prev);
            m_raw_cin_prev = CIN; m_raw_din_prev = DIN;
            while (m_syn_cin.size() > IDLE_CYC + 1) begin
                void'(m_syn_cin.pop_front());
                void'(m_syn_din.pop_front());
            end
            m_tend = nidle && !m_idle;
            m_idle = nidle;
            n = m_syn_din.size();
            m_tstart = m_syn_din[n-2] && !m_syn_din[n-1] && m_syn_cin[n-1];
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge CLK) begin
        chk("err_en", int'(ERR_EN), int'(m_en_f()));
        chk("busy", int'(BUSY), int'(m_run));
        chk("done", int'(DONE), int'(m_ending));
        chk("inj_done", int'(INJ_DONE), m_inj_done);
    end

    function automatic bit m_en_f();
        return m_armed || m_injecting;
    endfunction

    // DONE pulse counter
    always @(negedge CLK) if (DONE) done_cnt++;

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic run_start(input int skip, input int inj);
        SKIP_CNT = 8'(skip);
        INJ_CNT  = 8'(inj);
        START = 1'b1;
        cyc(1);
        START = 1'b0;
    endtask

    // One MBus transaction; optional START/ABORT pulse or reset at a given bit
    task automatic txn(input int nbits, input int start_bit, input int abort_bit, input int reset_bit);
        bit did_rst = 0;
        DIN = 1'b0;
        cyc(3);
        for (int i = 0; i < nbits; i++) begin
            CIN = 1'b0;
            DIN = 1'(i & 1);
            if (i == start_bit) begin
                START = 1'b1; cyc(1); START = 1'b0; cyc(1);
            end else if (i == abort_bit) begin
                ABORT = 1'b1; cyc(1); ABORT = 1'b0; cyc(1);
            end else if (i == reset_bit) begin
                #2 RESETn = 1'b0;
                #1;
                chk("rst_err_en_async", int'(ERR_EN), 0);
                chk("rst_busy_async", int'(BUSY), 0);
                did_rst = 1;
                @(negedge CLK);
                cyc(1);
            end else begin
                cyc(2);
            end
            if (i == nbits / 2) en_q.push_back(ERR_EN);
            CIN = 1'b1;
            cyc(2);
        end
        CIN = 1'b0; DIN = 1'b0; cyc(2);
        CIN = 1'b1; cyc(2);
        DIN = 1'b1;
        if (did_rst) RESETn = 1'b1;
        cyc(IDLE_CYC + 8);
    endtask

    initial begin
        int d0;
        cyc(3);
        chk("reset_err_en", int'(ERR_EN), 0);
        chk("reset_busy", int'(BUSY), 0);
        chk("reset_inj_done", int'(INJ_DONE), 0);
        RESETn = 1'b1;
        cyc(IDLE_CYC + 8);

        // skip 2, inject 1 over four transactions; a START while busy is ignored
        en_q.delete(); d0 = done_cnt;
        run_start(2, 1); cyc(4);
        txn(6, -1, -1, -1);
        SKIP_CNT = 8'd0; START = 1'b1; cyc(1); START = 1'b0;
        txn(6, -1, -1, -1); txn(6, -1, -1, -1); txn(6, -1, -1, -1);
        chk("s1_txn1_en", int'(en_q[0]), 0);
        chk("s1_txn2_en", int'(en_q[1]), 0);
        chk("s1_txn3_en", int'(en_q[2]), 1);
        chk("s1_txn4_en", int'(en_q[3]), 0);
        chk("s1_inj_done", int'(INJ_DONE), 1);
        chk("s1_busy", int'(BUSY), 0);
        chk("s1_done_pulses", done_cnt - d0, 1);

        // skip 0, inject 3 over five transactions
        en_q.delete();
        run_start(0, 3); cyc(4);
        for (int t = 0; t < 5; t++) txn(5, -1, -1, -1);
        chk("s2_txn1_en", int'(en_q[0]), 1);
        chk("s2_txn3_en", int'(en_q[2]), 1);
        chk("s2_txn4_en", int'(en_q[3]), 0);
        chk("s2_txn5_en", int'(en_q[4]), 0);
        chk("s2_inj_done", int'(INJ_DONE), 3);

        // zero injections on an idle bus
        run_start(5, 0);
        chk("s3_busy_c1", int'(BUSY), 1);
        chk("s3_done_c1", int'(DONE), 0);
        cyc(1);
        chk("s3_done_c2", int'(DONE), 1);
        cyc(1);
        chk("s3_done_c3", int'(DONE), 0);
        chk("s3_busy_c3", int'(BUSY), 0);
        chk("s3_inj_done", int'(INJ_DONE), 0);
        cyc(4);

        // START mid-transaction with skip 1
        en_q.delete();
        SKIP_CNT = 8'd1; INJ_CNT = 8'd1;
        txn(6, 1, -1, -1); txn(6, -1, -1, -1); txn(6, -1, -1, -1);
        chk("s4_ongoing_en", int'(en_q[0]), 0);
        chk("s4_skipped_en", int'(en_q[1]), 0);
        chk("s4_injected_en", int'(en_q[2]), 1);
        chk("s4_inj_done", int'(INJ_DONE), 1);

        // ABORT during INJECT completes the transaction
        en_q.delete(); d0 = done_cnt;
        run_start(0, 2); cyc(4);
        txn(6, -1, 2, -1);
        chk("s5_en_held", int'(en_q[0]), 1);
        chk("s5_inj_done", int'(INJ_DONE), 1);
        chk("s5_busy", int'(BUSY), 0);
        chk("s5_done_pulses", done_cnt - d0, 1);

        // ABORT during SKIP
        run_start(3, 1); cyc(4);
        txn(4, -1, -1, -1);
        ABORT = 1'b1; cyc(1); ABORT = 1'b0;
        chk("s6_done", int'(DONE), 1);
        chk("s6_err_en", int'(ERR_EN), 0);
        cyc(1);
        chk("s6_busy", int'(BUSY), 0);
        cyc(4);

        // ABORT and START in the same IDLE cycle
        SKIP_CNT = 8'd0; INJ_CNT = 8'd1;
        START = 1'b1; ABORT = 1'b1; cyc(1);
        START = 1'b0; ABORT = 1'b0;
        chk("s7_busy", int'(BUSY), 0);
        cyc(4);

        // reset in the middle of an injected transaction, then a clean run
        en_q.delete();
        run_start(0, 1); cyc(4);
        txn(6, -1, -1, 2);
        chk("s8_busy_after_rst", int'(BUSY), 0);
        chk("s8_inj_done_after_rst", int'(INJ_DONE), 0);
        run_start(0, 1); cyc(4);
        txn(6, -1, -1, -1);
        chk("s8_rerun_en", int'(en_q[1]), 1);
        chk("s8_rerun_inj_done", int'(INJ_DONE), 1);
        chk("s8_rerun_busy", int'(BUSY), 0);

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
